wb_commit_unit: RTL and testbench

- Parameterised write-back/commit stage for the RV pipeline; sits after the memory stage and drives the register-file write port.
- Selects the write-back source (ALU result, load data, or PC+4) from the instruction opcode.
- Aligns and sign/zero-extends load data, suppresses writes to x0 and to non-writing instructions, and flags misaligned or illegal loads.
- Keeps a retired-instruction counter; the registered write port doubles as the WB-to-EX forwarding source.

---
 rtl/riscv_pkg.sv | 42 ++++
 rtl/load_align_ext.sv | 51 +++++
 rtl/wb_commit_unit.sv | 92 +++++++++
 tb/tb_wb_commit_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV decode constants and write-back source selection.
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_MEM, WB_PC4} wb_sel_e;

    // Write-back source from opcode; the 32-bit-op groups only exist on RV64.
    function automatic wb_sel_e decode_wb_sel(input logic [6:0] opc, input logic rv64);
        wb_sel_e sel;
        sel = WB_NONE;
        case (opc)
            OPC_LOAD:                             sel = WB_MEM;
            OPC_JAL, OPC_JALR:                    sel = WB_PC4;
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: sel = WB_ALU;
            OPC_OP_32, OPC_OP_IMM_32:             sel = rv64 ? WB_ALU : WB_NONE;
            default:                              sel = WB_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/load_align_ext.sv
// Shifts the addressed byte lane down and sign/zero-extends it; flags bad funct3 or misalignment.
module load_align_ext
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]                    funct3,
    input  logic [$clog2(XLEN/8)-1:0]     offset,
    input  logic [XLEN-1:0]               mem_rdata,
    output logic [XLEN-1:0]               ext_data,
    output logic                          err
);
    localparam int unsigned OFF_W = $clog2(XLEN/8);

    logic [XLEN-1:0] shifted;
    logic [2:0]      off3;

    assign shifted = mem_rdata >> {offset, 3'b000};
    assign off3    = 3'(offset);

    always_comb begin
        ext_data = '0;
        err      = 1'b0;
        case (funct3)
            F3_LB:  ext_data = XLEN'($signed(shifted[7:0]));
            F3_LBU: ext_data = XLEN'(shifted[7:0]);
            F3_LH: begin
                err      = off3[0];
                ext_data = XLEN'($signed(shifted[15:0]));
            end
            F3_LHU: begin
                err      = off3[0];
                ext_data = XLEN'(shifted[15:0]);
            end
            F3_LW: begin
                err      = (off3[1:0] != 2'b00);
                ext_data = XLEN'($signed(shifted[31:0]));
            end
            F3_LWU: begin
                err      = (XLEN != 64) || (off3[1:0] != 2'b00);
                ext_data = XLEN'(shifted[31:0]);
            end
            F3_LD: begin
                err      = (XLEN != 64) || (off3 != 3'b000);
                ext_data = shifted;
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_commit_unit.sv
// Write-back/commit stage: selects and registers the register-file write, counts retired instructions.
module wb_commit_unit
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  hold,
    input  logic [31:0]           fetched_instruction,
    input  logic [XLEN-1:0]       alu_result,
    input  logic [XLEN-1:0]       mem_rdata,
    input  logic [XLEN-1:0]       pc,
    input  logic                  reg_write_enable,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    output logic                  load_err,
    output logic [CNT_W-1:0]      instret
);
    localparam int unsigned OFF_W = $clog2(XLEN/8);

    logic            acc_c;
    logic [6:0]      opcode_c;
    logic [4:0]      rd_c;
    logic [2:0]      funct3_c;
    wb_sel_e         sel_c;
    logic [XLEN-1:0] ld_data_c;
    logic            ld_bad_c;
    logic            ld_err_c;
    logic [XLEN-1:0] wdata_c;
    logic            we_c;
    logic            unused_instr_c;

    assign in_ready = ~hold;
    assign acc_c    = in_valid & ~hold;

    assign opcode_c = fetched_instruction[6:0];
    assign rd_c     = fetched_instruction[11:7];
    assign funct3_c = fetched_instruction[14:12];
    assign unused_instr_c = ^fetched_instruction[31:15];

    assign sel_c = decode_wb_sel(opcode_c, (XLEN == 64));

    load_align_ext #(.XLEN(XLEN)) u_load_align_ext (
        .funct3    (funct3_c),
        .offset    (alu_result[OFF_W-1:0]),
        .mem_rdata (mem_rdata),
        .ext_data  (ld_data_c),
        .err       (ld_bad_c)
    );

    // Load errors only matter for actual loads.
    assign ld_err_c = (sel_c == WB_MEM) & ld_bad_c;

    always_comb begin
        wdata_c = alu_result;
        case (sel_c)
            WB_MEM:  wdata_c = ld_data_c;
            WB_PC4:  wdata_c = pc + XLEN'(4);
            default: wdata_c = alu_result;
        endcase
    end

    assign we_c = acc_c & reg_write_enable & (sel_c != WB_NONE) & (rd_c != 5'd0) & ~ld_err_c;

    // Registered write port, which also serves as the WB-to-EX forwarding source.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            load_err <= 1'b0;
            instret  <= '0;
        end else begin
            rf_we    <= we_c;
            load_err <= acc_c & ld_err_c;
            if (we_c) begin
                rf_waddr <= REG_ADDR_W'(rd_c);
                rf_wdata <= wdata_c;
            end
            if (acc_c) begin
                instret <= instret + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed self-checking bench for wb_commit_unit (main instance plus a 3-bit-counter instance for wrap).
module tb_wb_commit_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        hold;
    logic [31:0] fetched_instruction;
    logic [31:0] alu_result;
    logic [31:0] mem_rdata;
    logic [31:0] pc;
    logic        reg_write_enable;

    logic        in_ready, rf_we, load_err;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] instret;

    logic        s_in_ready, s_rf_we, s_load_err;
    logic [4:0]  s_rf_waddr;
    logic [31:0] s_rf_wdata;
    logic [2:0]  s_instret;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_commit_unit #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .hold(hold),
        .fetched_instruction(fetched_instruction), .alu_result(alu_result),
        .mem_rdata(mem_rdata), .pc(pc), .reg_write_enable(reg_write_enable),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .load_err(load_err), .instret(instret)
    );

    wb_commit_unit #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(3)) dut_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .hold(hold),
        .fetched_instruction(fetched_instruction), .alu_result(alu_result),
        .mem_rdata(mem_rdata), .pc(pc), .reg_write_enable(reg_write_enable),
        .rf_we(s_rf_we), .rf_waddr(s_rf_waddr), .rf_wdata(s_rf_wdata),
        .load_err(s_load_err), .instret(s_instret)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Present one instruction for exactly one accepting edge, then sample 1 time unit later.
    task automatic issue(input logic [31:0] ins, input logic [31:0] alu, input logic [31:0] mem,
                         input logic [31:0] p, input logic rwe);
        fetched_instruction = ins;
        alu_result          = alu;
        mem_rdata           = mem;
        pc                  = p;
        reg_write_enable    = rwe;
        in_valid            = 1'b1;
        hold                = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic chk_port(input string tag, input logic we, input logic [4:0] wa,
                            input logic [31:0] wd, input logic le, input logic [31:0] ir);
        chk({tag, ".we"},   64'(rf_we),    64'(we));
        chk({tag, ".wa"},   64'(rf_waddr), 64'(wa));
        chk({tag, ".wd"},   64'(rf_wdata), 64'(wd));
        chk({tag, ".lerr"}, 64'(load_err), 64'(le));
        chk({tag, ".ret"},  64'(instret),  64'(ir));
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        hold = 1'b0;
        fetched_instruction = 32'h0;
        alu_result = 32'h0;
        mem_rdata = 32'h0;
        pc = 32'h0;
        reg_write_enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_port("reset", 1'b0, 5'd0, 32'h0, 1'b0, 32'd0);
        chk("reset.small_ret", 64'(s_instret), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_idle", 64'(in_ready), 64'd1);

        issue(32'h002082B3, 32'h0000_1234, 32'h0, 32'h0, 1'b1);
        chk_port("add_x5", 1'b1, 5'd5, 32'h0000_1234, 1'b0, 32'd1);

        issue(32'h0000_0303, 32'h0000_1003, 32'h80FF_FFFF, 32'h0, 1'b1);
        chk_port("lb_off3", 1'b1, 5'd6, 32'hFFFF_FF80, 1'b0, 32'd2);
        issue(32'h0000_4303, 32'h0000_1003, 32'h80FF_FFFF, 32'h0, 1'b1);
        chk_port("lbu_off3", 1'b1, 5'd6, 32'h0000_0080, 1'b0, 32'd3);

        issue(32'h0000_1303, 32'h0000_1001, 32'h80FF_FFFF, 32'h0, 1'b1);
        chk_port("lh_misal", 1'b0, 5'd6, 32'h0000_0080, 1'b1, 32'd4);
        @(posedge clk);
        #1;
        chk("lerr_pulse_end", 64'(load_err), 64'd0);
        chk("we_idle", 64'(rf_we), 64'd0);

        issue(32'h0000_5303, 32'h0000_1002, 32'h8001_2345, 32'h0, 1'b1);
        chk_port("lhu_off2", 1'b1, 5'd6, 32'h0000_8001, 1'b0, 32'd5);
        issue(32'h0000_1303, 32'h0000_1002, 32'h8001_2345, 32'h0, 1'b1);
        chk_port("lh_off2", 1'b1, 5'd6, 32'hFFFF_8001, 1'b0, 32'd6);

        issue(32'h0000_2303, 32'h0000_2000, 32'hDEAD_BEEF, 32'h0, 1'b1);
        chk_port("lw_off0", 1'b1, 5'd6, 32'hDEAD_BEEF, 1'b0, 32'd7);
        issue(32'h0000_2303, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0, 1'b1);
        chk_port("lw_misal", 1'b0, 5'd6, 32'hDEAD_BEEF, 1'b1, 32'd8);
        issue(32'h0000_6303, 32'h0000_2000, 32'h1234_5678, 32'h0, 1'b1);
        chk_port("lwu_rv32", 1'b0, 5'd6, 32'hDEAD_BEEF, 1'b1, 32'd9);
        issue(32'h0000_3303, 32'h0000_2000, 32'h1234_5678, 32'h0, 1'b1);
        chk_port("ld_rv32", 1'b0, 5'd6, 32'hDEAD_BEEF, 1'b1, 32'd10);

        issue(32'h0000_00EF, 32'h0, 32'h0, 32'h0000_0100, 1'b1);
        chk_port("jal_x1", 1'b1, 5'd1, 32'h0000_0104, 1'b0, 32'd11);
        issue(32'h0000_006F, 32'h0, 32'h0, 32'h0000_0200, 1'b1);
        chk_port("jal_x0", 1'b0, 5'd1, 32'h0000_0104, 1'b0, 32'd12);
        issue(32'h0000_0167, 32'h0, 32'h0, 32'hFFFF_FFFC, 1'b1);
        chk_port("jalr_wrap", 1'b1, 5'd2, 32'h0000_0000, 1'b0, 32'd13);

        issue(32'h002082B3, 32'h0000_5555, 32'h0, 32'h0, 1'b0);
        chk_port("add_rwe0", 1'b0, 5'd2, 32'h0000_0000, 1'b0, 32'd14);

        fetched_instruction = 32'h002083B3;
        alu_result = 32'h0000_0077;
        reg_write_enable = 1'b1;
        in_valid = 1'b1;
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("hold.ready", 64'(in_ready), 64'd0);
            chk("hold.we", 64'(rf_we), 64'd0);
            chk("hold.ret", 64'(instret), 64'd14);
        end
        hold = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk_port("hold_release", 1'b1, 5'd7, 32'h0000_0077, 1'b0, 32'd15);
        @(posedge clk);
        #1;
        chk("after_release.we", 64'(rf_we), 64'd0);
        chk("after_release.ret", 64'(instret), 64'd15);

        issue(32'h002082B3, 32'h0000_00AA, 32'h0, 32'h0, 1'b1);
        chk_port("b2b_first", 1'b1, 5'd5, 32'h0000_00AA, 1'b0, 32'd16);
        issue(32'h002082B3, 32'h0000_00BB, 32'h0, 32'h0, 1'b1);
        chk_port("b2b_second", 1'b1, 5'd5, 32'h0000_00BB, 1'b0, 32'd17);

        fetched_instruction = 32'h002082B3;
        alu_result = 32'h0000_00CC;
        in_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk_port("async_rst", 1'b0, 5'd0, 32'h0, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk_port("rst_discard", 1'b0, 5'd0, 32'h0, 1'b0, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(32'h0011_2223, 32'h0000_0004, 32'h0, 32'h0, 1'b1);
        chk_port("store", 1'b0, 5'd0, 32'h0, 1'b0, 32'd1);
        chk("store.small_ret", 64'(s_instret), 64'd1);

        for (int i = 0; i < 6; i++) begin
            issue(32'h002082B3, 32'(i), 32'h0, 32'h0, 1'b1);
        end
        chk("pre_wrap.small_ret", 64'(s_instret), 64'd7);
        issue(32'h002082B3, 32'h0000_0009, 32'h0, 32'h0, 1'b1);
        chk("wrap.small_ret", 64'(s_instret), 64'd0);
        chk("wrap.big_ret", 64'(instret), 64'd8);
        chk("wrap.wd", 64'(rf_wdata), 64'h9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
